// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared types and constants for the vending machine change path.
//   denom_e  : coin denominations handled by the dispenser (Q, D, N)
//   state_e  : change_dispenser control states
//   *_CENTS  : coin values in cents
//   *_W      : widths of the coin count inputs and the remaining-coin
//              and shortfall counters
//   Q_TO_* / D_TO_N : how many smaller coins replace one larger coin
// ---------------------------------------------------------------------------
package vending_pkg;

  typedef enum logic [1:0] {
    DEN_Q = 2'd0,
    DEN_D = 2'd1,
    DEN_N = 2'd2
  } denom_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int QUART_CENTS = 25;
  localparam int DIME_CENTS  = 10;
  localparam int NICK_CENTS  = 5;

  localparam int COUNT_W = 9;
  localparam int Q_REM_W = 9;
  localparam int D_REM_W = 11;
  localparam int N_REM_W = 12;
  localparam int SHORT_W = 15;

  // A quarter is paid back as two dimes plus whatever nickels make up the
  // rest; a dime is paid back purely in nickels.
  localparam int Q_TO_D = 2;
  localparam int Q_TO_N = (QUART_CENTS - Q_TO_D * DIME_CENTS) / NICK_CENTS;
  localparam int D_TO_N = DIME_CENTS / NICK_CENTS;

endpackage

// File: rtl/change_dispenser_if.sv
// ---------------------------------------------------------------------------
// change_dispenser_if
// Bundles the request, hopper and sensor signals of the change dispenser.
//   start              : one-cycle request strobe
//   quart/dim/nick     : coin counts to pay out
//   q/d/n_empty        : hopper-empty flags
//   coin_sensed        : coin exit sensor
//   eject_q/d/n        : hopper eject strobes
//   busy/done          : progress and completion pulse
//   shortfall          : cents that could not be paid
// master drives requests and sensor inputs; slave is the dispenser itself.
// ---------------------------------------------------------------------------
interface change_dispenser_if;
  import vending_pkg::*;

  logic               start;
  logic [COUNT_W-1:0] quart;
  logic [COUNT_W-1:0] dim;
  logic [COUNT_W-1:0] nick;
  logic               q_empty;
  logic               d_empty;
  logic               n_empty;
  logic               coin_sensed;
  logic               eject_q;
  logic               eject_d;
  logic               eject_n;
  logic               busy;
  logic               done;
  logic [SHORT_W-1:0] shortfall;

  modport master (
    output start, quart, dim, nick, q_empty, d_empty, n_empty, coin_sensed,
    input  eject_q, eject_d, eject_n, busy, done, shortfall
  );

  modport slave (
    input  start, quart, dim, nick, q_empty, d_empty, n_empty, coin_sensed,
    output eject_q, eject_d, eject_n, busy, done, shortfall
  );

endinterface

// File: rtl/dispense_timer.sv
// ---------------------------------------------------------------------------
// dispense_timer
// Loadable up-counter with an equality compare, shared by the dispenser for
// the eject acknowledge timeout, the eject strobe width and the gap length.
//   clk, rst     : clock, synchronous active-low reset
//   load_i       : load load_val_i this cycle (wins over en_i)
//   en_i         : count up by one
//   load_val_i   : value loaded on load_i
//   cmp_val_i    : compare value
//   count_o      : current count
//   match_o      : count_o equals cmp_val_i
// ---------------------------------------------------------------------------
module dispense_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] cmp_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             match_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Loading restarts the interval; otherwise the count advances only while
  // the owner says the interval is running. Wrap-around is never reached
  // because every interval ends on a compare match.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign match_o = (count_q == cmp_val_i);

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Pays out change one coin at a time, quarters first, then dimes, then
// nickels. Each coin must be confirmed by the exit sensor. An empty or
// jammed hopper is replaced by smaller coins, and whatever the nickel hopper
// cannot cover is reported in cents as the shortfall.
//   clk, rst : clock, synchronous active-low reset
//   bus      : change_dispenser_if slave port (see the interface file)
// Parameters:
//   PULSE_CYCLES : cycles each eject strobe stays high
//   ACK_TIMEOUT  : cycles allowed for the sensor after an eject starts
//   GAP_CYCLES   : idle cycles between ejects
// ---------------------------------------------------------------------------
module change_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  change_dispenser_if.slave  bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] PULSE_VAL   = TW'(PULSE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] GAP_VAL     = TW'(GAP_CYCLES);
  localparam logic [TW-1:0] FIRST_VAL   = TW'(1);

  state_e             state_q, state_d;
  denom_e             den_q, den_d;
  logic [Q_REM_W-1:0] qRem_q, qRem_d;
  logic [D_REM_W-1:0] dRem_q, dRem_d;
  logic [N_REM_W-1:0] nRem_q, nRem_d;
  logic [SHORT_W-1:0] short_q, short_d;
  logic [2:0]         jam_q, jam_d;

  logic ejectQ_q, ejectQ_d;
  logic ejectD_q, ejectD_d;
  logic ejectN_q, ejectN_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic strobeOn;

  logic          timerLoad;
  logic          timerEn;
  logic [TW-1:0] timerCmp;
  logic [TW-1:0] timerCount;
  logic          timerMatch;

  logic qAvail;
  logic dAvail;
  logic nAvail;
  logic ackValid;

  // A hopper may be used only if it reports coins and has not jammed during
  // the current payout.
  assign qAvail = !bus.q_empty && !jam_q[DEN_Q];
  assign dAvail = !bus.d_empty && !jam_q[DEN_D];
  assign nAvail = !bus.n_empty && !jam_q[DEN_N];

  // The sensor is only believed from the second eject cycle on, so a coin
  // still passing from the previous eject cannot confirm the new one.
  assign ackValid = bus.coin_sensed && (timerCount != FIRST_VAL);

  // The one timer restarts at 1 whenever an eject or gap begins and runs
  // while either is in progress; its compare target follows the state.
  assign timerLoad = (state_d != state_q) &&
                     ((state_d == ST_EJECT) || (state_d == ST_GAP));
  assign timerEn   = (state_q == ST_EJECT) || (state_q == ST_GAP);
  assign timerCmp  = (state_q == ST_GAP) ? GAP_VAL : TIMEOUT_VAL;

  dispense_timer #(
    .WIDTH (TW)
  ) uTimer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timerLoad),
    .en_i       (timerEn),
    .load_val_i (FIRST_VAL),
    .cmp_val_i  (timerCmp),
    .count_o    (timerCount),
    .match_o    (timerMatch)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter bookkeeping. SELECT picks the largest coin still
  // owed; if its hopper cannot be used, the whole remaining count of that
  // coin is converted into smaller coins (or into shortfall for nickels) and
  // SELECT is re-entered on the next cycle to try again.
  always_comb begin
    state_d = state_q;
    den_d   = den_q;
    qRem_d  = qRem_q;
    dRem_d  = dRem_q;
    nRem_d  = nRem_q;
    short_d = short_q;
    jam_d   = jam_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          qRem_d  = Q_REM_W'(bus.quart);
          dRem_d  = D_REM_W'(bus.dim);
          nRem_d  = N_REM_W'(bus.nick);
          short_d = '0;
          jam_d   = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (qRem_q != '0) begin
          if (qAvail) begin
            den_d   = DEN_Q;
            state_d = ST_EJECT;
          end else begin
            dRem_d = dRem_q + D_REM_W'(qRem_q) * D_REM_W'(Q_TO_D);
            nRem_d = nRem_q + N_REM_W'(qRem_q) * N_REM_W'(Q_TO_N);
            qRem_d = '0;
          end
        end else if (dRem_q != '0) begin
          if (dAvail) begin
            den_d   = DEN_D;
            state_d = ST_EJECT;
          end else begin
            nRem_d = nRem_q + N_REM_W'(dRem_q) * N_REM_W'(D_TO_N);
            dRem_d = '0;
          end
        end else if (nRem_q != '0) begin
          if (nAvail) begin
            den_d   = DEN_N;
            state_d = ST_EJECT;
          end else begin
            short_d = short_q + SHORT_W'(nRem_q) * SHORT_W'(NICK_CENTS);
            nRem_d  = '0;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_EJECT: begin
        if (ackValid) begin
          case (den_q)
            DEN_Q:   qRem_d = qRem_q - 1'b1;
            DEN_D:   dRem_d = dRem_q - 1'b1;
            DEN_N:   nRem_d = nRem_q - 1'b1;
            default: ;
          endcase
          state_d = ST_GAP;
        end else if (timerMatch) begin
          jam_d[den_q] = 1'b1;
          state_d      = ST_SELECT;
        end
      end
      ST_GAP: begin
        if (timerMatch) begin
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode. Every output is registered, so the values are derived
  // from the state being entered. The strobe is raised on entry to EJECT
  // and kept while the running count is still short of the pulse width.
  always_comb begin
    busy_d   = (state_d == ST_SELECT) || (state_d == ST_EJECT) ||
               (state_d == ST_GAP);
    done_d   = (state_d == ST_DONE);
    strobeOn = 1'b0;
    if (state_d == ST_EJECT) begin
      strobeOn = (state_q != ST_EJECT) || (timerCount < PULSE_VAL);
    end
    ejectQ_d = strobeOn && (den_d == DEN_Q);
    ejectD_d = strobeOn && (den_d == DEN_D);
    ejectN_d = strobeOn && (den_d == DEN_N);
  end

  // Counters, jam flags and output registers. Reset clears everything,
  // including a strobe that is in the middle of an eject.
  always_ff @(posedge clk) begin
    if (!rst) begin
      den_q    <= DEN_Q;
      qRem_q   <= '0;
      dRem_q   <= '0;
      nRem_q   <= '0;
      short_q  <= '0;
      jam_q    <= '0;
      ejectQ_q <= 1'b0;
      ejectD_q <= 1'b0;
      ejectN_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      den_q    <= den_d;
      qRem_q   <= qRem_d;
      dRem_q   <= dRem_d;
      nRem_q   <= nRem_d;
      short_q  <= short_d;
      jam_q    <= jam_d;
      ejectQ_q <= ejectQ_d;
      ejectD_q <= ejectD_d;
      ejectN_q <= ejectN_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.eject_q   = ejectQ_q;
  assign bus.eject_d   = ejectD_q;
  assign bus.eject_n   = ejectN_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.shortfall = short_q;

endmodule
